robs_operand_sequencer: RTL and testbench

Upstream feeder and result collector for the Robertson's signed multiplier core.
- Accepts signed operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Starts the core once per pair by pulsing its reset, holds the operands stable, and waits for done.
- Registers the product and presents it downstream under valid/ready backpressure.

---
 rtl/robs_seq_pkg.sv | 21 ++
 rtl/robs_operand_fifo.sv | 46 ++++
 rtl/robs_operand_sequencer.sv | 161 ++++++++++++++++
 tb/tb_robs_operand_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/robs_seq_pkg.sv
// Shared types for the Robertson multiplier operand sequencer.
// States, default timeout and counter-width helper used by robs_operand_sequencer.
package robs_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        HOLD   = 3'd4
    } seq_state_e;

    localparam int TIMEOUT_DEFAULT = 64;

    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(TIMEOUT_DEFAULT);

endpackage

// File: rtl/robs_operand_fifo.sv
// Synchronous FIFO holding {multiplier, multiplicand} pairs; head is visible
// combinationally on rdata_o, so a pushed entry appears the cycle after its push.
module robs_operand_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/robs_operand_sequencer.sv
// Feeds operand pairs to a Robertson signed multiplier core and collects its products.
// Optional RUN watchdog enabled by defining ROBS_SEQ_TIMEOUT_EN.
module robs_operand_sequencer
    import robs_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_multiplier,
    input  logic [WIDTH-1:0]   in_multiplicand,
    output logic               core_reset,
    output logic [WIDTH-1:0]   core_multiplier,
    output logic [WIDTH-1:0]   core_multiplicand,
    input  logic               core_done,
    input  logic [2*WIDTH-1:0] core_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy,
    output logic               err_timeout
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("robs_operand_sequencer: DEPTH must be a power of two >= 2, TIMEOUT >= 2");
    end

    seq_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               ovalid_q, ovalid_d;
    logic [2*WIDTH-1:0] oprod_q, oprod_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*WIDTH-1:0] fifo_rdata;

    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & in_ready;

    robs_operand_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({in_multiplier, in_multiplicand}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef ROBS_SEQ_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        mult_d   = mult_q;
        mcand_d  = mcand_q;
        ovalid_d = ovalid_q;
        oprod_d  = oprod_q;
        fifo_pop = 1'b0;
`ifdef ROBS_SEQ_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop          = 1'b1;
                    {mult_d, mcand_d} = fifo_rdata;
                    state_d           = LAUNCH;
                end
            end
            LAUNCH: state_d = ARM;
            // done may still be left over from the previous multiply here
            ARM: begin
                state_d = RUN;
`ifdef ROBS_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            RUN: begin
                if (core_done) begin
                    oprod_d  = core_product;
                    ovalid_d = 1'b1;
                    state_d  = HOLD;
                end
`ifdef ROBS_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    oprod_d  = '0;
                    ovalid_d = 1'b1;
                    state_d  = HOLD;
                end
                cnt_d = cnt_q + 1'b1;
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop          = 1'b1;
                        {mult_d, mcand_d} = fifo_rdata;
                        state_d           = LAUNCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mult_q   <= '0;
            mcand_q  <= '0;
            ovalid_q <= 1'b0;
            oprod_q  <= '0;
        end else begin
            state_q  <= state_d;
            mult_q   <= mult_d;
            mcand_q  <= mcand_d;
            ovalid_q <= ovalid_d;
            oprod_q  <= oprod_d;
        end
    end

`ifdef ROBS_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign core_reset        = reset | (state_q == LAUNCH);
    assign core_multiplier   = mult_q;
    assign core_multiplicand = mcand_q;
    assign out_valid         = ovalid_q;
    assign out_product       = oprod_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_robs_operand_sequencer.sv
// Directed bench for robs_operand_sequencer with a behavioural multiplier core
// (auto mode) or a hand-driven stub core (manual mode).
module tb_robs_operand_sequencer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_multiplier, in_multiplicand;
    logic          core_reset;
    logic [W-1:0]  core_multiplier, core_multiplicand;
    logic          core_done;
    logic [2*W-1:0] core_product;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_product;
    logic          busy;
    logic          err_timeout;

    logic          auto_core;
    logic          man_done;
    logic [2*W-1:0] man_prod;
    logic [3:0]    mcnt;
    logic          mdone;
    logic [2*W-1:0] mprod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    robs_operand_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_multiplier     (in_multiplier),
        .in_multiplicand   (in_multiplicand),
        .core_reset        (core_reset),
        .core_multiplier   (core_multiplier),
        .core_multiplicand (core_multiplicand),
        .core_done         (core_done),
        .core_product      (core_product),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_product       (out_product),
        .busy              (busy),
        .err_timeout       (err_timeout)
    );

    // Behavioural core: done rises ~9 cycles after its reset and stays high.
    always @(posedge clk) begin
        if (core_reset) begin
            mcnt  <= 4'd0;
            mdone <= 1'b0;
        end else if (mcnt != 4'd8) begin
            mcnt <= mcnt + 4'd1;
        end else begin
            mdone <= 1'b1;
            mprod <= $signed(core_multiplier) * $signed(core_multiplicand);
        end
    end

    assign core_done    = auto_core ? mdone : man_done;
    assign core_product = auto_core ? mprod : man_prod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_b [2];
    logic [15:0] exp_c [6];
    int n, got, acc;
    logic ok, pushed;
    logic [15:0] held;

    initial begin
        exp_b = '{16'hFFEB, 16'h4000};
        exp_c = '{16'd2, 16'd6, 16'd12, 16'd20, 16'd30, 16'd42};
        reset = 1'b1; in_valid = 1'b0; in_multiplier = '0; in_multiplicand = '0;
        out_ready = 1'b1; auto_core = 1'b1; man_done = 1'b0; man_prod = '0;

        // reset state
        tick; tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_mult", core_multiplier, 0);
        chk("rst_core_mcand", core_multiplicand, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        reset = 1'b0;
        tick;

        // A: single push, latency and operand stability
        in_valid = 1'b1; in_multiplier = 8'd5; in_multiplicand = 8'd3;   // cycle 0
        tick; in_valid = 1'b0;                                            // cycle 1
        chk("a_c1_core_reset", core_reset, 0);
        chk("a_c1_busy", busy, 0);
        tick;                                                             // cycle 2
        chk("a_c2_core_reset", core_reset, 1);
        chk("a_c2_mult", core_multiplier, 5);
        chk("a_c2_mcand", core_multiplicand, 3);
        tick;                                                             // cycle 3
        chk("a_c3_core_reset", core_reset, 0);
        n = 0; ok = 1'b1;
        while (!core_done && n < 50) begin
            if (core_multiplier != 8'd5 || core_multiplicand != 8'd3 || out_valid || core_reset) ok = 1'b0;
            tick; n++;
        end
        chk("a_done_in_time", (n < 50), 1);
        chk("a_operands_stable", ok, 1);
        chk("a_valid_at_done", out_valid, 0);
        tick;
        chk("a_valid_after_done", out_valid, 1);
        chk("a_product_5x3", out_product, 16'h000F);
        tick;
        chk("a_valid_dropped", out_valid, 0);

        // B: streamed signed pairs
        in_valid = 1'b1; in_multiplier = 8'hFD; in_multiplicand = 8'd7;
        tick; in_multiplier = 8'h80; in_multiplicand = 8'h80;
        tick; in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 80; c++) begin
            if (out_valid) begin
                if (got < 2) chk("b_product", out_product, exp_b[got]);
                got++;
            end
            tick;
        end
        chk("b_result_count", got, 2);

        // C: backpressure with six pairs
        out_ready = 1'b0; acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (acc < 6);
            in_multiplier = 8'(acc + 1); in_multiplicand = 8'(acc + 2);
            pushed = in_valid && in_ready;
            tick;
            if (pushed) acc++;
        end
        in_valid = 1'b0;
        chk("c_accepted_before_full", acc, 5);
        chk("c_in_ready_low", in_ready, 0);
        ok = 1'b1; held = '0; n = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                if (n == 0) held = out_product;
                else if (out_product != held) ok = 1'b0;
                n++;
            end
            tick;
        end
        chk("c_held_valid", out_valid, 1);
        chk("c_held_product", out_product, 16'd2);
        chk("c_held_stable", ok, 1);
        out_ready = 1'b1; got = 0;
        for (int c = 0; c < 200; c++) begin
            in_valid = (acc < 6);
            in_multiplier = 8'(acc + 1); in_multiplicand = 8'(acc + 2);
            pushed = in_valid && in_ready;
            if (out_valid) begin
                if (got < 6) chk("c_drain_product", out_product, exp_c[got]);
                got++;
            end
            tick;
            if (pushed) acc++;
        end
        in_valid = 1'b0;
        chk("c_drain_count", got, 6);
        chk("c_all_pushed", acc, 6);

        // D: reset three cycles into RUN with a second pair queued
        in_valid = 1'b1; in_multiplier = 8'd9; in_multiplicand = 8'd9;    // cycle 0
        tick; in_multiplier = 8'd10; in_multiplicand = 8'd10;              // cycle 1
        tick; in_valid = 1'b0;                                             // cycle 2
        tick; tick; tick; tick; tick;                                      // cycle 7
        chk("d_busy_in_run", busy, 1);
        reset = 1'b1;
        tick;
        chk("d_out_valid", out_valid, 0);
        chk("d_core_reset", core_reset, 1);
        chk("d_busy", busy, 0);
        chk("d_in_ready", in_ready, 1);
        reset = 1'b0;
        tick; tick;
        chk("d_fifo_flushed", busy, 0);
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid || busy) ok = 1'b0;
            tick;
        end
        chk("d_no_stale", ok, 1);

        // E: stub core holding done through LAUNCH/ARM
        auto_core = 1'b0; man_done = 1'b1; man_prod = 16'hDEAD;
        in_valid = 1'b1; in_multiplier = 8'd2; in_multiplicand = 8'd2;    // cycle 0
        tick; in_valid = 1'b0;                                             // cycle 1
        tick;                                                              // cycle 2
        chk("e_launch", core_reset, 1);
        tick; tick;                                                        // cycle 4
        chk("e_arm_masked", out_valid, 0);
        man_prod = 16'h1234;
        tick;                                                              // cycle 5
        chk("e_valid", out_valid, 1);
        chk("e_run_product", out_product, 16'h1234);
        tick;
        chk("e_idle", busy, 0);

`ifdef ROBS_SEQ_TIMEOUT_EN
        // F: watchdog fires, next pair still launches
        man_done = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_multiplier = 8'd3; in_multiplicand = 8'd4;    // cycle 0
        tick; in_multiplier = 8'd5; in_multiplicand = 8'd6;                // cycle 1
        tick; in_valid = 1'b0;                                             // cycle 2
        for (int c = 0; c < 17; c++) tick;                                 // cycle 19
        chk("f_no_valid_yet", out_valid, 0);
        chk("f_no_err_yet", err_timeout, 0);
        tick;                                                              // cycle 20
        chk("f_valid", out_valid, 1);
        chk("f_err", err_timeout, 1);
        chk("f_zero_product", out_product, 0);
        tick;                                                              // cycle 21
        chk("f_next_launch", core_reset, 1);
        chk("f_next_mult", core_multiplier, 5);
        chk("f_next_mcand", core_multiplicand, 6);
        tick; tick;                                                        // cycle 23 RUN
        man_done = 1'b1; man_prod = 16'h001E;
        tick;
        chk("f_second_product", out_product, 16'h001E);
        chk("f_err_sticky", err_timeout, 1);
        reset = 1'b1; tick; reset = 1'b0; tick;
        chk("f_err_cleared", err_timeout, 0);
`else
        // F: without the watchdog RUN waits indefinitely
        man_done = 1'b0;
        in_valid = 1'b1; in_multiplier = 8'd3; in_multiplicand = 8'd4;
        tick; in_valid = 1'b0;
        for (int c = 0; c < 100; c++) tick;
        chk("f_still_waiting", out_valid, 0);
        chk("f_still_busy", busy, 1);
        chk("f_err_tied", err_timeout, 0);
        reset = 1'b1; tick; reset = 1'b0; tick;
        chk("f_idle_after_reset", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
